cpu_bus: RTL and testbench

- Address decoder and responder on the CPU side of the system bus.
- Takes the CPU core's address/data/valid outputs and returns read data with a valid flag.
- Serves the 2 KiB internal work RAM directly.
- Forwards PPU-register and cartridge accesses over req/ack ports, with a timeout and open-bus fallback.

---
 rtl/cpu_bus.sv | 177 +++++++++++++++++
 tb/tb_cpu_bus.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus.sv
// CPU-side bus decoder/responder: serves internal work RAM, forwards PPU and
// cartridge accesses over req/ack with a timeout and open-bus fallback.
module cpu_bus #(
    parameter int RAM_ADDR_WIDTH = 11,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic [15:0] cpu_address_i,
    input  logic        cpu_address_valid_i,
    input  logic        cpu_write_i,
    input  logic [7:0]  cpu_data_i,
    output logic [7:0]  cpu_data_o,
    output logic        cpu_data_valid_o,
    output logic [2:0]  ppu_address_o,
    output logic [7:0]  ppu_data_o,
    output logic        ppu_write_o,
    output logic        ppu_req_o,
    input  logic [7:0]  ppu_data_i,
    input  logic        ppu_ack_i,
    output logic [15:0] cart_address_o,
    output logic [7:0]  cart_data_o,
    output logic        cart_write_o,
    output logic        cart_req_o,
    input  logic [7:0]  cart_data_i,
    input  logic        cart_ack_i
);

    // state | meaning
    // IDLE  | no request held, waiting for a valid address
    // RAM   | one-cycle internal RAM read or write
    // IO    | IO stub: reads return open bus, writes dropped
    // EXT   | PPU or cartridge handshake in flight, timeout running
    // DONE  | result presented while the CPU holds the same request
    typedef enum logic [2:0] {IDLE, RAM, IO, EXT, DONE} state_t;

    state_t                    state;
    logic [15:0]               cap_addr;
    logic                      cap_write;
    logic [7:0]                cap_data;
    logic [7:0]                open_bus;
    logic [7:0]                data_q;
    logic [7:0]                ram_q;
    logic                      use_ram;
    logic                      to_ppu;
    logic [7:0]                cnt;
    logic [7:0]                mem [0:(1 << RAM_ADDR_WIDTH) - 1];
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic                      same;
    logic                      is_ram;
    logic                      is_ppu;
    logic                      is_io;
    logic                      take;
    logic                      ext_ack;
    logic [7:0]                ext_data;

    always_comb begin
        ram_idx  = cap_addr[RAM_ADDR_WIDTH-1:0];
        same     = ({cpu_address_i, cpu_write_i, cpu_data_i} == {cap_addr, cap_write, cap_data});
        is_ram   = (cpu_address_i[15:13] == 3'b000);
        is_ppu   = (cpu_address_i[15:13] == 3'b001);
        is_io    = (cpu_address_i[15:5] == 11'h200);
        take     = cpu_address_valid_i && ((state == IDLE) || ((state == DONE) && !same));
        ext_ack  = to_ppu ? ppu_ack_i : cart_ack_i;
        ext_data = to_ppu ? ppu_data_i : cart_data_i;
    end

    // RAM read data bypasses the output register so the array maps to a plain sync RAM
    assign cpu_data_o = use_ram ? ram_q : data_q;

    always_ff @(posedge clock_i) begin
        if (state == RAM && cap_write)
            mem[ram_idx] <= cap_data;
        ram_q <= mem[ram_idx];
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state            <= IDLE;
            cap_addr         <= '0;
            cap_write        <= 1'b0;
            cap_data         <= '0;
            open_bus         <= '0;
            data_q           <= '0;
            use_ram          <= 1'b0;
            to_ppu           <= 1'b0;
            cnt              <= '0;
            cpu_data_valid_o <= 1'b0;
            ppu_address_o    <= '0;
            ppu_data_o       <= '0;
            ppu_write_o      <= 1'b0;
            ppu_req_o        <= 1'b0;
            cart_address_o   <= '0;
            cart_data_o      <= '0;
            cart_write_o     <= 1'b0;
            cart_req_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_data_valid_o <= 1'b0;
                    use_ram          <= 1'b0;
                end
                RAM: begin
                    state            <= DONE;
                    use_ram          <= !cap_write;
                    cpu_data_valid_o <= cpu_address_valid_i && same;
                    if (cap_write)
                        open_bus <= cap_data;
                end
                IO: begin
                    state            <= DONE;
                    data_q           <= open_bus;
                    cpu_data_valid_o <= cpu_address_valid_i && same;
                    if (cap_write)
                        open_bus <= cap_data;
                end
                EXT: begin
                    if (ext_ack || cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        state            <= DONE;
                        ppu_req_o        <= 1'b0;
                        cart_req_o       <= 1'b0;
                        cpu_data_valid_o <= cpu_address_valid_i && same;
                        if (cap_write)
                            open_bus <= cap_data;
                        else if (ext_ack) begin
                            data_q   <= ext_data;
                            open_bus <= ext_data;
                        end else
                            data_q <= open_bus;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (use_ram)
                        open_bus <= ram_q;
                    if (!cpu_address_valid_i) begin
                        state            <= IDLE;
                        use_ram          <= 1'b0;
                        cpu_data_valid_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // a new request is captured on the same edge that drops the previous result
            if (take) begin
                cap_addr         <= cpu_address_i;
                cap_write        <= cpu_write_i;
                cap_data         <= cpu_data_i;
                use_ram          <= 1'b0;
                cpu_data_valid_o <= 1'b0;
                cnt              <= '0;
                if (is_ram)
                    state <= RAM;
                else if (is_io)
                    state <= IO;
                else begin
                    state  <= EXT;
                    to_ppu <= is_ppu;
                    if (is_ppu) begin
                        ppu_req_o     <= 1'b1;
                        ppu_address_o <= cpu_address_i[2:0];
                        ppu_data_o    <= cpu_data_i;
                        ppu_write_o   <= cpu_write_i;
                    end else begin
                        cart_req_o     <= 1'b1;
                        cart_address_o <= cpu_address_i;
                        cart_data_o    <= cpu_data_i;
                        cart_write_o   <= cpu_write_i;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus.sv
// Directed bench for cpu_bus: a transaction-level model of RAM contents and open
// bus supplies the expected read value, checked every cycle a result is presented.
module tb_cpu_bus;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cpu_address = '0;
    logic        cpu_address_valid = 1'b0;
    logic        cpu_write = 1'b0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_data_valid;
    logic [2:0]  ppu_address;
    logic [7:0]  ppu_wdata;
    logic        ppu_write;
    logic        ppu_req;
    logic [7:0]  ppu_rdata = '0;
    logic        ppu_ack = 1'b0;
    logic [15:0] cart_address;
    logic [7:0]  cart_wdata;
    logic        cart_write;
    logic        cart_req;
    logic [7:0]  cart_rdata = '0;
    logic        cart_ack = 1'b0;

    int total = 0;
    int bad = 0;

    cpu_bus #(.RAM_ADDR_WIDTH(11), .TIMEOUT_CYCLES(16)) dut (
        .clock_i(clock), .reset_n_i(reset_n),
        .cpu_address_i(cpu_address), .cpu_address_valid_i(cpu_address_valid),
        .cpu_write_i(cpu_write), .cpu_data_i(cpu_wdata),
        .cpu_data_o(cpu_rdata), .cpu_data_valid_o(cpu_data_valid),
        .ppu_address_o(ppu_address), .ppu_data_o(ppu_wdata), .ppu_write_o(ppu_write),
        .ppu_req_o(ppu_req), .ppu_data_i(ppu_rdata), .ppu_ack_i(ppu_ack),
        .cart_address_o(cart_address), .cart_data_o(cart_wdata), .cart_write_o(cart_write),
        .cart_req_o(cart_req), .cart_data_i(cart_rdata), .cart_ack_i(cart_ack)
    );

    always #5 clock = ~clock;

    // reference model: RAM image and open-bus byte
    logic [7:0] ram_m [0:2047];
    logic [7:0] ob_m = 8'h00;
    logic [7:0] exp_now = 8'h00;
    logic       exp_rd_now = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // expected read value of an address given the model and an external answer
    function automatic logic [7:0] model_read(input logic [15:0] a, input logic [7:0] ext);
        if (a < 16'h2000)       return ram_m[a[10:0]];
        else if (a < 16'h4000)  return ext;
        else if (a < 16'h4020)  return ob_m;
        else                    return ext;
    endfunction

    task automatic set_req(input logic [15:0] a, input logic wr, input logic [7:0] d, input logic [7:0] ext);
        exp_rd_now        = !wr;
        exp_now           = wr ? 8'h00 : model_read(a, ext);
        cpu_address       = a;
        cpu_write         = wr;
        cpu_wdata         = d;
        cpu_address_valid = 1'b1;
    endtask

    // per-edge snapshot: how long the current tuple has been held, and its expected value
    logic [25:0] last_tup = '0;
    int          age = 0;
    logic [7:0]  exp_q = 8'h00;
    logic        exp_rd_q = 1'b0;
    int          ppu_rises = 0;
    logic        ppu_req_prev = 1'b0;

    always @(posedge clock) begin
        if (!reset_n) begin
            age = 0;
        end else if ({cpu_address, cpu_write, cpu_wdata, cpu_address_valid} == last_tup && cpu_address_valid) begin
            age = age + 1;
        end else begin
            age = cpu_address_valid ? 1 : 0;
        end
        last_tup = {cpu_address, cpu_write, cpu_wdata, cpu_address_valid};
        exp_q    = exp_now;
        exp_rd_q = exp_rd_now;
    end

    always @(negedge clock) begin
        if (reset_n) begin
            check("req_exclusive", {31'd0, ppu_req & cart_req}, 32'd0);
            if (ppu_req && !ppu_req_prev)
                ppu_rises++;
            ppu_req_prev = ppu_req;
            if (cpu_data_valid) begin
                check("valid_needs_held_tuple", {31'd0, age >= 2}, 32'd1);
                check("no_req_in_done", {30'd0, ppu_req, cart_req}, 32'd0);
                if (exp_rd_q)
                    check("model_read_data", {24'd0, cpu_rdata}, {24'd0, exp_q});
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 2048; i++) ram_m[i] = 8'h00;

        #2;
        check("rst_valid", {31'd0, cpu_data_valid}, 32'd0);
        check("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
        check("rst_reqs", {30'd0, ppu_req, cart_req}, 32'd0);
        check("rst_cart_addr", {16'd0, cart_address}, 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;

        // RAM write 0x0000 = 11, first request after reset
        set_req(16'h0000, 1'b1, 8'h11, 8'h00);
        tick(); check("ram_wr0_lat1", {31'd0, cpu_data_valid}, 32'd0);
        tick(); check("ram_wr0_lat2", {31'd0, cpu_data_valid}, 32'd1);
        ram_m[0] = 8'h11; ob_m = 8'h11;

        // RAM write 5A at 0x0123, then mirrored reads
        set_req(16'h0123, 1'b1, 8'h5A, 8'h00);
        tick(); check("ram_wr_drop", {31'd0, cpu_data_valid}, 32'd0);
        tick(); check("ram_wr_valid", {31'd0, cpu_data_valid}, 32'd1);
        ram_m[11'h123] = 8'h5A; ob_m = 8'h5A;
        repeat (3) tick();
        check("ram_wr_hold", {31'd0, cpu_data_valid}, 32'd1);

        set_req(16'h0923, 1'b0, 8'h00, 8'h00);
        tick(); check("mirror1_lat1", {31'd0, cpu_data_valid}, 32'd0);
        tick(); check("mirror1_valid", {31'd0, cpu_data_valid}, 32'd1);
        check("mirror1_data", {24'd0, cpu_rdata}, 32'h5A);
        set_req(16'h1923, 1'b0, 8'h00, 8'h00);
        tick(); check("mirror2_lat1", {31'd0, cpu_data_valid}, 32'd0);
        tick(); check("mirror2_valid", {31'd0, cpu_data_valid}, 32'd1);
        check("mirror2_data", {24'd0, cpu_rdata}, 32'h5A);
        ob_m = 8'h5A;

        // PPU write through mirror 0x2008
        ppu_rises = 0;
        set_req(16'h2008, 1'b1, 8'h80, 8'h00);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ppu_req", {31'd0, ppu_req}, 32'd1);
            check("ppu_addr", {29'd0, ppu_address}, 32'd0);
            check("ppu_write", {31'd0, ppu_write}, 32'd1);
            check("ppu_wdata", {24'd0, ppu_wdata}, 32'h80);
            check("ppu_valid_low", {31'd0, cpu_data_valid}, 32'd0);
        end
        ppu_ack = 1'b1;
        tick();
        ppu_ack = 1'b0;
        ob_m = 8'h80;
        check("ppu_done_valid", {31'd0, cpu_data_valid}, 32'd1);
        check("ppu_req_drop", {31'd0, ppu_req}, 32'd0);
        repeat (5) tick();
        check("ppu_single_req", ppu_rises, 32'd1);

        // cartridge read acked after 5 cycles
        cart_rdata = 8'hC3;
        set_req(16'h8000, 1'b0, 8'h00, 8'hC3);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("cart_req", {31'd0, cart_req}, 32'd1);
            check("cart_addr", {16'd0, cart_address}, 32'h8000);
            check("cart_write", {31'd0, cart_write}, 32'd0);
        end
        cart_ack = 1'b1;
        tick();
        cart_ack = 1'b0;
        ob_m = 8'hC3;
        check("cart_valid", {31'd0, cpu_data_valid}, 32'd1);
        check("cart_data", {24'd0, cpu_rdata}, 32'hC3);
        check("cart_req_drop", {31'd0, cart_req}, 32'd0);

        // IO stub read returns open bus
        set_req(16'h4010, 1'b0, 8'h00, 8'h00);
        tick(); tick();
        check("io_valid", {31'd0, cpu_data_valid}, 32'd1);
        check("io_data", {24'd0, cpu_rdata}, 32'hC3);

        // cartridge timeout
        cart_rdata = 8'h55;
        set_req(16'hFFFC, 1'b0, 8'h00, ob_m);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (cart_req) n++;
            else break;
        end
        check("timeout_req_cycles", n, 32'd16);
        check("timeout_valid", {31'd0, cpu_data_valid}, 32'd1);
        check("timeout_data", {24'd0, cpu_rdata}, 32'hC3);

        // request change while a cart read is pending
        cart_rdata = 8'h77;
        set_req(16'h9000, 1'b0, 8'h00, 8'h77);
        tick(); tick();
        check("stale_req_up", {31'd0, cart_req}, 32'd1);
        set_req(16'h0000, 1'b0, 8'h00, 8'h00);
        tick(); tick();
        check("stale_still_pending", {31'd0, cart_req}, 32'd1);
        cart_ack = 1'b1;
        tick();
        cart_ack = 1'b0;
        check("stale_suppressed", {31'd0, cpu_data_valid}, 32'd0);
        tick(); check("stale_recapture", {31'd0, cpu_data_valid}, 32'd0);
        tick(); check("after_stale_valid", {31'd0, cpu_data_valid}, 32'd1);
        check("after_stale_data", {24'd0, cpu_rdata}, 32'h11);
        ob_m = 8'h11;
        tick();
        set_req(16'h4000, 1'b0, 8'h00, 8'h00);
        tick(); tick();
        check("io_after_ram", {24'd0, cpu_rdata}, 32'h11);

        // asynchronous reset during an external access
        set_req(16'hC000, 1'b0, 8'h00, 8'h00);
        tick(); tick();
        check("pre_reset_req", {31'd0, cart_req}, 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_req", {31'd0, cart_req}, 32'd0);
        check("async_rst_valid", {31'd0, cpu_data_valid}, 32'd0);
        check("async_rst_data", {24'd0, cpu_rdata}, 32'd0);
        ob_m = 8'h00;
        set_req(16'h0123, 1'b0, 8'h00, 8'h00);
        tick();
        reset_n = 1'b1;
        tick(); check("post_rst_lat1", {31'd0, cpu_data_valid}, 32'd0);
        tick(); check("post_rst_valid", {31'd0, cpu_data_valid}, 32'd1);
        check("post_rst_data", {24'd0, cpu_rdata}, 32'h5A);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
